// File: rtl/knight_sprite_anim.sv
// Animated, optionally mirrored sprite renderer: 3-stage pixel pipeline
// (address -> ROM -> palette) with frame stepping on vsync boundaries.
module knight_sprite_anim #(
  parameter int SPRITE_W   = 50,
  parameter int SPRITE_H   = 64,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 3,
  parameter int HOLD       = 6,
  parameter int MODE       = 0,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(FRAMES*SPRITE_W*SPRITE_H),
  localparam int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on,
  output logic [FW-1:0]     frame_idx
);
  localparam int HW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int FRAME_SZ = SPRITE_W * SPRITE_H;

  logic [9:0]        shx_q, shy_q;
  logic              flip_q;
  logic [HW-1:0]     hold_q, hold_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              dir_q, dir_d;
  logic              pend_q, pend_d;
  logic [1:0]        hit_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        red_q, green_q, blue_q;
  logic              on_q;

  // 11-bit differences: bit 10 set means the pixel lies left/above the sprite
  logic [10:0] lx, ly, col;
  logic        hit_s1;

  always_comb begin
    lx     = {1'b0, DrawX} - {1'b0, shx_q};
    ly     = {1'b0, DrawY} - {1'b0, shy_q};
    hit_s1 = blank & ~lx[10] & (lx < 11'(SPRITE_W)) & ~ly[10] & (ly < 11'(SPRITE_H));
    col    = flip_q ? 11'(SPRITE_W - 1) - lx : lx;
    addr_d = '0;
    if (hit_s1)
      addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ) + ADDR_W'(ly) * ADDR_W'(SPRITE_W)
             + ADDR_W'(col);
  end

  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    dir_d   = dir_q;
    pend_d  = pend_q | anim_restart;
    if (frame_start) begin
      if (pend_q) begin
        hold_d  = '0;
        frame_d = '0;
        dir_d   = 1'b1;
        pend_d  = anim_restart;
      end else if (anim_en) begin
        if (hold_q != HW'(HOLD - 1)) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
          if (FRAMES == 1)
            frame_d = '0;
          else if (MODE == 0)
            frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
          else if (dir_q) begin
            if (frame_q == FW'(FRAMES - 1)) begin
              dir_d   = 1'b0;
              frame_d = frame_q - 1'b1;
            end else
              frame_d = frame_q + 1'b1;
          end else begin
            if (frame_q == '0) begin
              dir_d   = 1'b1;
              frame_d = frame_q + 1'b1;
            end else
              frame_d = frame_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      shx_q   <= '0;
      shy_q   <= '0;
      flip_q  <= 1'b0;
      hold_q  <= '0;
      frame_q <= '0;
      dir_q   <= 1'b1;
      pend_q  <= 1'b0;
      hit_q   <= '0;
      addr_q  <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      on_q    <= 1'b0;
    end else begin
      if (frame_start) begin
        shx_q  <= pos_x;
        shy_q  <= pos_y;
        flip_q <= flip_h;
      end
      hold_q  <= hold_d;
      frame_q <= frame_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      hit_q   <= {hit_q[0], hit_s1};
      addr_q  <= addr_d;
      if (hit_q[1] && rom_q != IDX_W'(TRANSP_IDX)) begin
        red_q   <= pal_red;
        green_q <= pal_green;
        blue_q  <= pal_blue;
        on_q    <= 1'b1;
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
        on_q    <= 1'b0;
      end
    end
  end

  assign rom_address = addr_q;
  assign pal_index   = rom_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign sprite_on   = on_q;
  assign frame_idx   = frame_q;
endmodule

// File: tb/tb_knight_sprite_anim.sv
// Two renderers (loop/HOLD=6 and ping-pong/HOLD=1) on shared stimulus, checked
// against a pixel/animation model driven by pulse counts and plain arithmetic.
module tb_knight_sprite_anim;
  localparam int SW = 50, SH = 64, FR = 4;

  logic       vga_clk = 0, reset = 0, blank = 0, frame_start = 0;
  logic [9:0] DrawX = 0, DrawY = 0, pos_x = 0, pos_y = 0;
  logic       flip_h = 0, anim_en = 0, anim_restart = 0;
  logic [13:0] a_addr, b_addr;
  logic [2:0]  a_q, b_q, a_pi, b_pi;
  logic [3:0]  a_pr, a_pg, a_pb, b_pr, b_pg, b_pb;
  logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_on, b_on;
  logic [1:0]  a_fr, b_fr;

  int n_chk = 0, n_fail = 0;

  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] rom_f(input int a);
    return 3'((a ^ (a >> 4) ^ 5) & 7);
  endfunction
  function automatic logic [3:0] pr(input logic [2:0] i); return 4'(i * 2 + 1); endfunction
  function automatic logic [3:0] pg(input logic [2:0] i); return 4'(i) ^ 4'hA;    endfunction
  function automatic logic [3:0] pb(input logic [2:0] i); return 4'd15 - 4'(i);   endfunction

  always @(posedge vga_clk) begin
    a_q <= rom_f(int'(a_addr));
    b_q <= rom_f(int'(b_addr));
  end
  assign a_pr = pr(a_pi); assign a_pg = pg(a_pi); assign a_pb = pb(a_pi);
  assign b_pr = pr(b_pi); assign b_pg = pg(b_pi); assign b_pb = pb(b_pi);

  knight_sprite_anim #(.MODE(0), .HOLD(6)) dut_a (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .anim_en(anim_en), .anim_restart(anim_restart), .rom_address(a_addr), .rom_q(a_q),
    .pal_index(a_pi), .pal_red(a_pr), .pal_green(a_pg), .pal_blue(a_pb),
    .red(a_r), .green(a_g), .blue(a_b), .sprite_on(a_on), .frame_idx(a_fr));

  knight_sprite_anim #(.MODE(1), .HOLD(1)) dut_b (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .anim_en(anim_en), .anim_restart(anim_restart), .rom_address(b_addr), .rom_q(b_q),
    .pal_index(b_pi), .pal_red(b_pr), .pal_green(b_pg), .pal_blue(b_pb),
    .red(b_r), .green(b_g), .blue(b_b), .sprite_on(b_on), .frame_idx(b_fr));

  // model: shadow position plus count of enabled pulses since the last restart
  int mshx = 0, mshy = 0, m_cnt = 0;
  bit mflip = 0, mpend = 0;

  typedef struct {int addr; bit on; int r; int g; int b;} pix_t;
  pix_t ha[3], hb[3];

  function automatic int frame_of(input int hold, input int mode);
    int n, k;
    n = m_cnt / hold;
    if (mode == 0) return n % FR;
    k = n % (2 * (FR - 1));
    return (k < FR) ? k : 2 * (FR - 1) - k;
  endfunction

  function automatic pix_t model_pix(input int x, input int y, input bit blk, input int fr);
    pix_t p;
    int lx, ly;
    logic [2:0] idx;
    p = '{default: 0};
    lx = x - mshx;
    ly = y - mshy;
    if (blk && lx >= 0 && lx < SW && ly >= 0 && ly < SH) begin
      p.addr = fr * SW * SH + ly * SW + (mflip ? SW - 1 - lx : lx);
      idx = rom_f(p.addr);
      if (idx != 0) begin
        p.on = 1; p.r = int'(pr(idx)); p.g = int'(pg(idx)); p.b = int'(pb(idx));
      end
    end
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int x, input int y, input bit blk, input bit fs,
                      input bit en, input bit rs, input bit rst);
    pix_t pa, pb_;
    DrawX = 10'(x); DrawY = 10'(y); blank = blk; frame_start = fs;
    anim_en = en; anim_restart = rs; reset = rst;
    pa  = model_pix(x, y, blk, frame_of(6, 0));
    pb_ = model_pix(x, y, blk, frame_of(1, 1));
    if (rst) begin
      pa = '{default: 0}; pb_ = pa;
      for (int i = 0; i < 3; i++) begin ha[i] = pa; hb[i] = pa; end
    end
    ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = pa;
    hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = pb_;
    @(posedge vga_clk);
    if (rst) begin
      mshx = 0; mshy = 0; mflip = 0; m_cnt = 0; mpend = 0;
    end else if (fs) begin
      mshx = int'(pos_x); mshy = int'(pos_y); mflip = flip_h;
      if (mpend) begin m_cnt = 0; mpend = rs; end
      else begin if (en) m_cnt++; if (rs) mpend = 1; end
    end else if (rs) mpend = 1;
    #1;
    chk("a.addr", 32'(a_addr), 32'(ha[0].addr));
    chk("a.on", 32'(a_on), 32'(ha[2].on));
    chk("a.rgb", {20'd0, a_r, a_g, a_b}, 32'((ha[2].r << 8) | (ha[2].g << 4) | ha[2].b));
    chk("a.frame", 32'(a_fr), 32'(frame_of(6, 0)));
    chk("b.addr", 32'(b_addr), 32'(hb[0].addr));
    chk("b.on", 32'(b_on), 32'(hb[2].on));
    chk("b.rgb", {20'd0, b_r, b_g, b_b}, 32'((hb[2].r << 8) | (hb[2].g << 4) | hb[2].b));
    chk("b.frame", 32'(b_fr), 32'(frame_of(1, 1)));
  endtask

  typedef struct {bit fl; int x; int y; bit blk; int exp_addr;} vec_t;
  vec_t tbl[12];
  int pp_seq[8] = '{1, 2, 3, 2, 1, 0, 1, 2};

  initial begin
    tbl[0]  = '{0, 100, 50, 1, 0};    tbl[1]  = '{0, 101, 50, 1, 1};
    tbl[2]  = '{0, 100, 51, 1, 50};   tbl[3]  = '{0, 149, 113, 1, 3199};
    tbl[4]  = '{0, 150, 50, 1, 0};    tbl[5]  = '{0, 99, 50, 1, 0};
    tbl[6]  = '{0, 100, 114, 1, 0};   tbl[7]  = '{0, 101, 50, 0, 0};
    tbl[8]  = '{1, 100, 51, 1, 99};   tbl[9]  = '{1, 149, 51, 1, 50};
    tbl[10] = '{1, 100, 50, 1, 49};   tbl[11] = '{1, 150, 51, 1, 0};

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst.addr", 32'(a_addr), 0); chk("rst.on", 32'(a_on), 0);
    chk("rst.frame", 32'(a_fr), 0); chk("rst.red", 32'(a_r), 0);

    pos_x = 100; pos_y = 50; flip_h = 0;
    step(0, 0, 0, 1, 0, 0, 0);
    // opaque index 5 at address 0, then transparent index at address 5
    step(100, 50, 1, 0, 0, 0, 0);
    chk("px5.addr", 32'(a_addr), 0);
    step(105, 50, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("px5.on", 32'(a_on), 1); chk("px5.red", 32'(a_r), 11);
    chk("px5.green", 32'(a_g), 15); chk("px5.blue", 32'(a_b), 10);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("transp.on", 32'(a_on), 0); chk("transp.red", 32'(a_r), 0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].fl != flip_h) begin
        flip_h = tbl[i].fl;
        step(0, 0, 0, 1, 0, 0, 0);
      end
      step(tbl[i].x, tbl[i].y, tbl[i].blk, 0, 0, 0, 0);
      chk("tbl.addr", 32'(a_addr), 32'(tbl[i].exp_addr));
      chk("tbl.addr_b", 32'(b_addr), 32'(tbl[i].exp_addr));
    end

    flip_h = 0;
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 30; i++) begin
      step(0, 0, 0, 1, 1, 0, 0);
      step(100, 50, 1, 0, 1, 0, 0);
      chk("loop.frame", 32'(a_fr), 32'((i / 6) % 4));
      if (i >= 18 && i < 24) chk("loop.base", 32'(a_addr), 9600);
      if (i <= 8) chk("pp.frame", 32'(b_fr), 32'(pp_seq[i-1]));
    end

    step(120, 60, 1, 0, 0, 1, 0);
    step(121, 60, 1, 0, 0, 0, 0);
    chk("restart.hold", 32'(a_fr), 1);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("restart.a", 32'(a_fr), 0); chk("restart.b", 32'(b_fr), 0);

    pos_x = 300;
    step(101, 50, 1, 0, 0, 0, 0);
    chk("oldpos.addr", 32'(a_addr), 1);
    step(0, 0, 0, 1, 0, 0, 0);
    step(301, 50, 1, 0, 0, 0, 0);
    chk("newpos.addr", 32'(a_addr), 1);
    step(101, 50, 1, 0, 0, 0, 0);
    chk("newpos.miss", 32'(a_addr), 0);

    step(300, 50, 1, 0, 0, 0, 0);
    step(302, 50, 1, 0, 0, 0, 0);
    step(303, 50, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("midrst.on", 32'(a_on), 0);
    end

    for (int c = 0; c < 3000; c++) begin
      bit fs, rs;
      int x, y;
      fs = ($urandom_range(0, 39) == 0);
      rs = !fs && ($urandom_range(0, 199) == 0);
      if (fs) begin
        if ($urandom_range(0, 1) != 0) begin
          pos_x = 10'($urandom_range(0, 700)); pos_y = 10'($urandom_range(0, 500));
        end else begin
          pos_x = 10'($urandom_range(0, 1023)); pos_y = 10'($urandom_range(0, 1023));
        end
        flip_h = 1'($urandom_range(0, 1));
      end
      x = mshx + int'($urandom_range(0, 70)) - 10;
      y = mshy + int'($urandom_range(0, 84)) - 10;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      step(x, y, ($urandom_range(0, 9) != 0), fs, ($urandom_range(0, 3) != 0), rs, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
